// File: rtl/ram_arb_pkg.sv
// Shared encodings for the two-port byte-RAM arbiter: access sizes, FSM states, port IDs.
package ram_arb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Size code 3 is not a legal encoding; it is sequenced as a full word.
  function automatic logic [2:0] beats_for_size(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, registered favoured-port pointer.
module rr_arb2
  import ram_arb_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       gnt_o
);

  logic fav_q, fav_d;

  // The pointer only moves on real contention, and then to the port that lost.
  always_comb begin
    gnt_o = PORT_I;
    fav_d = fav_q;
    if (req_i[PORT_I] && req_i[PORT_D]) begin
      gnt_o = fav_q;
    end else if (req_i[PORT_D]) begin
      gnt_o = PORT_D;
    end
    if (take_i && req_i[PORT_I] && req_i[PORT_D]) begin
      fav_d = ~fav_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fav_q <= RR_INIT;
    end else begin
      fav_q <= fav_d;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one byte-wide RAM between fetch (port I) and load/store (port D),
// sequencing each access as 1, 2 or 4 little-endian byte beats.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter bit RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic              ram_r_wn,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  state_e            state_q, state_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       result_q, result_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic [2:0]        n_q, n_d;
  logic [1:0]        k_q, k_d;
  logic              gnt, take, last_beat, wr_beat;
  logic [ADDR_W-1:0] beat_addr;
  logic [4:0]        lane;

  rr_arb2 #(.RR_INIT(RR_INIT)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  ({d_req, i_req}),
    .take_i (take),
    .gnt_o  (gnt)
  );

  // Beat address wraps naturally in ADDR_W bits.
  assign beat_addr = addr_q + ADDR_W'(k_q);
  assign lane      = {k_q, 3'b000};
  assign last_beat = ({1'b0, k_q} == (n_q - 3'd1));
  assign wr_beat   = (state_q == ST_BUSY) && we_q;

  assign ram_addr  = (state_q == ST_BUSY) ? beat_addr : last_addr_q;
  assign ram_r_wn  = ~wr_beat;
  assign ram_wdata = wr_beat ? wdata_q[lane +: 8] : 8'h00;
  assign i_done    = (state_q == ST_DONE) && (port_q == PORT_I);
  assign d_done    = (state_q == ST_DONE) && (port_q == PORT_D);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    n_d         = n_q;
    k_d         = k_q;
    result_d    = result_q;
    last_addr_d = last_addr_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    take        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          take     = 1'b1;
          port_d   = gnt;
          k_d      = 2'd0;
          result_d = 32'h0;
          state_d  = ST_BUSY;
          if (gnt == PORT_I) begin
            addr_d  = i_addr;
            we_d    = 1'b0;
            wdata_d = 32'h0;
            n_d     = 3'd4;
          end else begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
            n_d     = beats_for_size(d_size);
          end
        end
      end
      ST_BUSY: begin
        last_addr_d = beat_addr;
        if (!we_q) begin
          result_d[lane +: 8] = ram_rdata;
        end
        k_d = k_q + 2'd1;
        // Publish the final result together with the last captured byte.
        if (last_beat) begin
          state_d = ST_DONE;
          if (port_q == PORT_I) begin
            i_rdata_d = result_d;
          end else begin
            d_rdata_d = result_d;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      port_q      <= PORT_I;
      we_q        <= 1'b0;
      addr_q      <= '0;
      last_addr_q <= '0;
      wdata_q     <= 32'h0;
      result_q    <= 32'h0;
      i_rdata_q   <= 32'h0;
      d_rdata_q   <= 32'h0;
      n_q         <= 3'd0;
      k_q         <= 2'd0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      wdata_q     <= wdata_d;
      result_q    <= result_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      n_q         <= n_d;
      k_q         <= k_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: byte-RAM model plus a byte-array reference of its expected contents.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int AW     = 12;
  localparam int MEM_SZ = 1 << AW;
  localparam bit RR     = 1'b0;
  localparam logic [AW-1:0] I_HOLD_ADDR = 12'h300;
  localparam logic [AW-1:0] D_HOLD_ADDR = 12'h400;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [1:0]    d_size;
  logic [31:0]   d_wdata, i_rdata, d_rdata;
  logic          i_done, d_done, ram_r_wn;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata, ram_rdata;

  logic [7:0] mem     [MEM_SZ];
  logic [7:0] ref_mem [MEM_SZ];
  logic [7:0] seed8;
  logic       mem_load;

  int checks     = 0;
  int errors     = 0;
  int wr_beats   = 0;
  int d_done_cnt = 0;

  // Clock and reset
  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(AW), .RR_INIT(RR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_done    (i_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_size    (d_size),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .ram_r_wn  (ram_r_wn),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a * 29) ^ (a >> 5)) + seed8;
  endfunction

  // RAM model: combinational read, write committed at the edge ending a write beat.
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int a = 0; a < MEM_SZ; a++) mem[a] <= init_byte(a);
    end else if (!ram_r_wn) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  always @(negedge clk) begin
    if (!ram_r_wn) wr_beats <= wr_beats + 1;
    if (d_done) d_done_cnt <= d_done_cnt + 1;
  end

  // Scoreboard helpers
  function automatic logic [31:0] ref_word(input logic [AW-1:0] addr, input int n);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < n; k++) w |= 32'(ref_mem[(int'(addr) + k) % MEM_SZ]) << (8 * k);
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: one complete access with request inputs scrambled mid-access.
  task automatic access(input bit port, input bit we, input logic [1:0] size,
                        input logic [AW-1:0] addr, input logic [31:0] wdata);
    int n, lat, wb0, a;
    bit seen;
    logic [31:0] exp, got;
    n = (port == PORT_I) ? 4 : (size == SZ_BYTE) ? 1 : (size == SZ_HALF) ? 2 : 4;
    exp = 32'h0;
    if (port == PORT_D && we) begin
      for (int k = 0; k < n; k++) begin
        a = (int'(addr) + k) % MEM_SZ;
        ref_mem[a] = wdata[8 * k +: 8];
      end
    end else begin
      exp = ref_word(addr, n);
    end
    @(posedge clk); #1;
    wb0 = wr_beats;
    if (port == PORT_I) begin
      i_addr = addr; i_req = 1'b1;
    end else begin
      d_we = we; d_size = size; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    end
    seen = 1'b0; lat = 0; got = 32'h0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (c == 2) begin
        i_addr = AW'($urandom); d_addr = AW'($urandom); d_wdata = $urandom;
        d_we = 1'($urandom); d_size = 2'($urandom_range(0, 3));
      end
      if (port == PORT_I ? i_done : d_done) begin
        seen = 1'b1; lat = c; got = (port == PORT_I) ? i_rdata : d_rdata;
      end
    end
    check(port == PORT_I ? "i_done_seen" : "d_done_seen", 32'(seen), 32'd1);
    i_req = 1'b0; d_req = 1'b0;
    if (seen) begin
      check(port == PORT_I ? "i_latency" : "d_latency", lat, n + 1);
      check(port == PORT_I ? "i_rdata" : "d_rdata", got, exp);
    end
    @(posedge clk); #1;
    check("write_beats", wr_beats - wb0, (port == PORT_D && we) ? n : 0);
  endtask

  // Requests held high continuously; expects strict alternation under contention.
  task automatic run_held(input bit use_i, input bit use_d, input int want);
    logic [31:0] exp_q[$];
    logic [31:0] exp_port_q[$];
    logic [31:0] exp_cyc_q[$];
    int got_n;
    bit nxt;
    nxt = (use_i && use_d) ? RR : use_d;
    for (int j = 0; j < want; j++) begin
      exp_port_q.push_back(32'(nxt));
      exp_q.push_back(nxt ? ref_word(D_HOLD_ADDR, 4) : ref_word(I_HOLD_ADDR, 4));
      exp_cyc_q.push_back(32'(5 + 6 * j));
      if (use_i && use_d) nxt = ~nxt;
    end
    @(posedge clk); #1;
    i_addr = I_HOLD_ADDR; d_addr = D_HOLD_ADDR; d_we = 1'b0; d_size = SZ_WORD;
    i_req = use_i; d_req = use_d;
    got_n = 0;
    for (int c = 0; c < 80 && got_n < want; c++) begin
      @(negedge clk);
      if (i_done || d_done) begin
        check("held_port", 32'(d_done), exp_port_q.pop_front());
        check("held_cycle", c, exp_cyc_q.pop_front());
        check("held_rdata", d_done ? d_rdata : i_rdata, exp_q.pop_front());
        got_n++;
      end
    end
    check("held_count", got_n, want);
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int dc0, mism;
    bit p;
    logic [1:0] sz;
    logic [AW-1:0] ad;
    i_req = 0; d_req = 0; d_we = 0; d_size = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    seed8 = 8'($urandom);
    for (int a = 0; a < MEM_SZ; a++) ref_mem[a] = init_byte(a);
    mem_load = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_i_done", 32'(i_done), 32'd0);
    check("rst_d_done", 32'(d_done), 32'd0);
    check("rst_ram_r_wn", 32'(ram_r_wn), 32'd1);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    @(posedge clk); #1;
    mem_load = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed: word write then fetch, sub-word merge, wrap-around
    access(PORT_D, 1'b1, SZ_WORD, 12'h100, 32'hDEADBEEF);
    access(PORT_I, 1'b0, SZ_WORD, 12'h100, 32'h0);
    check("word_fetch_const", i_rdata, 32'hDEADBEEF);
    access(PORT_D, 1'b1, SZ_BYTE, 12'h201, 32'h0000005A);
    access(PORT_D, 1'b1, SZ_BYTE, 12'h200, 32'h00000011);
    access(PORT_D, 1'b0, SZ_HALF, 12'h200, 32'h0);
    check("half_read_const", d_rdata, 32'h00005A11);
    access(PORT_D, 1'b0, SZ_WORD, 12'hFFE, 32'h0);
    access(PORT_D, 1'b1, SZ_HALF, 12'hFFF, 32'h0000C0DE);
    access(PORT_I, 1'b0, SZ_WORD, 12'hFFD, 32'h0);
    access(PORT_D, 1'b0, 2'd3, 12'h0FF, 32'h0);

    // Randomized accesses, biased towards the top of the address space
    for (int t = 0; t < 40; t++) begin
      p  = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      ad = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(12'hFF8, 12'hFFF)) : AW'($urandom);
      access(p, 1'($urandom), sz, ad, $urandom);
    end

    // Reset during the third beat of a word write
    @(posedge clk); #1;
    dc0 = d_done_cnt;
    ref_mem[12'h010] = 8'hD4;
    ref_mem[12'h011] = 8'hC3;
    d_we = 1'b1; d_size = SZ_WORD; d_addr = 12'h010; d_wdata = 32'hA1B2C3D4; d_req = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    d_req = 1'b0;
    #1;
    check("midrst_ram_r_wn", 32'(ram_r_wn), 32'd1);
    check("midrst_ram_addr", 32'(ram_addr), 32'd0);
    check("midrst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("midrst_d_done", 32'(d_done), 32'd0);
    check("midrst_d_rdata", d_rdata, 32'h0);
    check("midrst_i_rdata", i_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_done", d_done_cnt - dc0, 0);
    check("midrst_partial", {16'h0, mem[12'h011], mem[12'h010]}, 32'h0000C3D4);

    // Contention straight after reset, then a single held requester
    run_held(1'b1, 1'b1, 4);
    run_held(1'b1, 1'b0, 2);

    mism = 0;
    for (int a = 0; a < MEM_SZ; a++) if (mem[a] !== ref_mem[a]) mism++;
    check("mem_final", mism, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
